// File: rtl/head_encrypt_sched.sv
// Round-robin scheduler: head flits (FT=00) go through the encryption engine, others bypass it. Optional timeout under HEAD_ENCRYPT_TIMEOUT_EN.
// Grant to out_valid: 1 cycle bypass, engine latency+2 head; out_valid holds until out_ready and no new grant is issued meanwhile.
module head_encrypt_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [128*NREQ-1:0]  req_flit,
  output logic [NREQ-1:0]      gnt,
  output logic                 eng_start,
  output logic [127:0]         eng_flit,
  input  logic                 eng_done,
  input  logic [127:0]         eng_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_flit,
  output logic [2:0]           out_src,
  output logic                 err_timeout
);

`ifdef HEAD_ENCRYPT_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t         state, state_nxt;
  logic [2:0]     rr_ptr;
  logic [2:0]     pick;
  logic           pick_vld;
  logic [127:0]   pick_flit;
  logic           pick_head;
  logic [7:0]     wait_cnt;
  logic           timeout_hit;
  logic           err_r;

  // rr_ptr is the first port to consider, i.e. one past the last granted port
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!pick_vld && req[i] && (i == idx)) begin
          pick_vld = 1'b1;
          pick     = 3'(i);
        end
      end
    end
  end

  always_comb begin
    pick_flit = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == 3'(i)) pick_flit = req_flit[128*i +: 128];
    end
  end

  assign pick_head   = (pick_flit[1:0] == 2'b00);
  // The counter reaches TIMEOUT on the cycle it would step to it; eng_done there still wins.
  assign timeout_hit = TIMEOUT_EN && (wait_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    eng_start = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld && rst_n) begin
          for (int i = 0; i < NREQ; i++) gnt[i] = (pick == 3'(i));
          state_nxt = pick_head ? ISSUE : HOLD;
        end
      end
      ISSUE: begin
        eng_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (eng_done)         state_nxt = HOLD;
        else if (timeout_hit) state_nxt = IDLE;
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      eng_flit <= '0;
      out_flit <= '0;
      out_src  <= '0;
      wait_cnt <= '0;
      err_r    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            out_src <= pick;
            rr_ptr  <= (int'(pick) == NREQ - 1) ? 3'd0 : pick + 3'd1;
            if (pick_head) eng_flit <= pick_flit;
            else           out_flit <= pick_flit;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (eng_done)         out_flit <= eng_result;
          else if (timeout_hit) err_r    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid   = (state == HOLD);
  assign err_timeout = TIMEOUT_EN & err_r;

endmodule

// File: tb/tb_head_encrypt_sched.sv
// Randomized bench for head_encrypt_sched with a transaction-level round-robin/engine model.
module tb_head_encrypt_sched;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [128*NREQ-1:0] req_flit;
  logic [NREQ-1:0]     gnt;
  logic                eng_start;
  logic [127:0]        eng_flit;
  logic                eng_done;
  logic [127:0]        eng_result;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        out_flit;
  logic [2:0]          out_src;
  logic                err_timeout;

  int n_cmp;
  int n_bad;
  int rr_last;
  bit err_exp;

  head_encrypt_sched #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_flit(req_flit), .gnt(gnt),
    .eng_start(eng_start), .eng_flit(eng_flit), .eng_done(eng_done),
    .eng_result(eng_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_flit(out_flit), .out_src(out_src), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Next requester strictly after the last granted port, wrapping around.
  function automatic int rr_pick(input logic [NREQ-1:0] m);
    for (int i = 1; i <= NREQ; i++) begin
      int q;
      q = (rr_last + i) % NREQ;
      if (m[q]) return q;
    end
    return 0;
  endfunction

  task automatic present(input logic [NREQ-1:0] mask, input bit head, output int p, output logic [127:0] flit);
    p = rr_pick(mask);
    for (int i = 0; i < NREQ; i++) req_flit[128*i +: 128] = rand128();
    flit = rand128();
    flit[1:0] = head ? 2'b00 : 2'($urandom_range(1, 3));
    req_flit[128*p +: 128] = flit;
    req = mask;
    #4;
    chk("gnt_onehot", 128'(gnt), 128'(1) << p);
    chk("ov_idle", 128'(out_valid), 128'(0));
    rr_last = p;
  endtask

  task automatic do_txn(input logic [NREQ-1:0] mask, input bit head, input int lat, input int stall);
    int p;
    logic [127:0] flit, res, exp;
    present(mask, head, p, flit);
    if (head) begin
      tick();
      eng_done   = 1'($urandom_range(0, 1));
      eng_result = rand128();
      #4;
      chk("eng_start", 128'(eng_start), 128'(1));
      chk("eng_flit", eng_flit, flit);
      chk("gnt_issue", 128'(gnt), 128'(0));
      res = rand128();
      for (int k = 1; k <= lat; k++) begin
        tick();
        eng_done   = (k == lat);
        eng_result = (k == lat) ? res : rand128();
        #4;
        chk("wait_ov", 128'(out_valid), 128'(0));
        chk("wait_gnt", 128'(gnt), 128'(0));
      end
      exp = res;
    end else begin
      exp = flit;
    end
    tick();
    eng_done = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) tick();
      out_ready  = (s == stall);
      eng_done   = 1'($urandom_range(0, 1));
      eng_result = rand128();
      #4;
      chk("hold_ov", 128'(out_valid), 128'(1));
      chk("hold_flit", out_flit, exp);
      chk("hold_src", 128'(out_src), 128'(p));
      chk("hold_gnt", 128'(gnt), 128'(0));
      chk("hold_start", 128'(eng_start), 128'(0));
    end
    tick();
    out_ready = 1'b0;
    eng_done  = 1'b0;
    req       = '0;
    #4;
    chk("err_flag", 128'(err_timeout), 128'(err_exp));
    chk("idle_ov", 128'(out_valid), 128'(0));
  endtask

  task automatic timeout_txn(input logic [NREQ-1:0] mask);
    int p;
    logic [127:0] flit, res;
    present(mask, 1'b1, p, flit);
    tick();
    #4;
    chk("to_start", 128'(eng_start), 128'(1));
    for (int k = 1; k <= TO; k++) begin
      tick();
      #4;
      chk("to_wait_ov", 128'(out_valid), 128'(0));
      chk("to_wait_gnt", 128'(gnt), 128'(0));
    end
`ifdef HEAD_ENCRYPT_TIMEOUT_EN
    tick();
    req = '0;
    err_exp = 1'b1;
    #4;
    chk("to_err", 128'(err_timeout), 128'(1));
    chk("to_ov", 128'(out_valid), 128'(0));
    tick();
    #4;
    chk("to_ov2", 128'(out_valid), 128'(0));
    chk("to_start2", 128'(eng_start), 128'(0));
`else
    for (int k = 0; k < 2 * TO; k++) begin
      tick();
      #4;
      chk("nto_ov", 128'(out_valid), 128'(0));
      chk("nto_gnt", 128'(gnt), 128'(0));
      chk("nto_err", 128'(err_timeout), 128'(0));
    end
    res = rand128();
    tick();
    eng_done   = 1'b1;
    eng_result = res;
    tick();
    eng_done  = 1'b0;
    out_ready = 1'b1;
    #4;
    chk("nto_ov_done", 128'(out_valid), 128'(1));
    chk("nto_flit", out_flit, res);
    chk("nto_src", 128'(out_src), 128'(p));
    tick();
    out_ready = 1'b0;
    req = '0;
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_gnt"}, 128'(gnt), 128'(0));
    chk({tag, "_start"}, 128'(eng_start), 128'(0));
    chk({tag, "_eflit"}, eng_flit, 128'(0));
    chk({tag, "_ov"}, 128'(out_valid), 128'(0));
    chk({tag, "_oflit"}, out_flit, 128'(0));
    chk({tag, "_src"}, 128'(out_src), 128'(0));
    chk({tag, "_err"}, 128'(err_timeout), 128'(0));
  endtask

  task automatic reset_in_wait();
    int p;
    logic [127:0] flit;
    present(4'($urandom_range(1, 15)), 1'b1, p, flit);
    tick();
    req = '0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n      = 1'b1;
    eng_done   = 1'b1;
    eng_result = rand128();
    rr_last    = NREQ - 1;
    err_exp    = 1'b0;
    #4;
    check_reset_vals("rstw_a");
    tick();
    eng_done = 1'b0;
    #4;
    check_reset_vals("rstw_b");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rr_last = NREQ - 1;
    err_exp = 1'b0;
    rst_n = 1'b0;
    req = '0;
    req_flit = '0;
    eng_done = 1'b0;
    eng_result = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    #4;
    check_reset_vals("reset");
    tick();
    rst_n = 1'b1;

    do_txn(4'b0100, 1'b1, 5, 0);
    do_txn(4'b0001, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) do_txn(4'b1111, 1'($urandom_range(0, 1)), $urandom_range(1, TO), 0);
    do_txn(4'($urandom_range(1, 15)), 1'b1, TO, 10);
    do_txn(4'($urandom_range(1, 15)), 1'b0, 0, 10);
    do_txn(4'($urandom_range(1, 15)), 1'b1, 1, 2);
    timeout_txn(4'($urandom_range(1, 15)));
    do_txn(4'($urandom_range(1, 15)), 1'b1, 3, 1);
    reset_in_wait();
    do_txn(4'b1111, 1'b0, 0, 0);
    for (int i = 0; i < 40; i++)
      do_txn(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom_range(1, TO), $urandom_range(0, 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
